// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_GPR general-purpose registers plus SP and ISR,
// two write ports (port 0 wins), two bypassed read ports, SP push/pop with sticky flags.
module regfile_mp #(
    parameter int unsigned     DATA_W   = 16,
    parameter int unsigned     NUM_GPR  = 8,
    parameter int unsigned     SEL_W    = 4,
    parameter int unsigned     SP_W     = 12,
    parameter logic [SP_W-1:0] SP_RESET = {SP_W{1'b1}}
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SEL_W-1:0]            rd_sel0,
    input  logic [SEL_W-1:0]            rd_sel1,
    output logic [DATA_W-1:0]           rd_data0,
    output logic [DATA_W-1:0]           rd_data1,
    input  logic                        wr_en0,
    input  logic                        wr_en1,
    input  logic [SEL_W-1:0]            wr_sel0,
    input  logic [SEL_W-1:0]            wr_sel1,
    input  logic [DATA_W-1:0]           wr_data0,
    input  logic [DATA_W-1:0]           wr_data1,
    input  logic                        sp_push,
    input  logic                        sp_pop,
    input  logic                        flag_clr,
    output logic                        stack_ovf,
    output logic                        stack_unf,
    output logic [NUM_GPR*DATA_W-1:0]   regs_out_flat,
    output logic [SP_W-1:0]             sp_out,
    output logic [SP_W-1:0]             isr_out
);

    localparam int unsigned SEL_SP  = NUM_GPR;
    localparam int unsigned SEL_ISR = NUM_GPR + 1;
    localparam int unsigned SEL_END = NUM_GPR + 2;

    logic [NUM_GPR-1:0][DATA_W-1:0] gpr_q;
    logic [NUM_GPR-1:0][DATA_W-1:0] gpr_d;
    logic [SP_W-1:0]                sp_q;
    logic [SP_W-1:0]                sp_d;
    logic [SP_W-1:0]                isr_q;
    logic [SP_W-1:0]                isr_d;
    logic                           ovf_q;
    logic                           ovf_d;
    logic                           unf_q;
    logic                           unf_d;

    logic [1:0][SEL_W-1:0]          rd_sel_s;
    logic [1:0][DATA_W-1:0]         rd_data_s;
    logic                           wr0_sp_s;
    logic                           wr1_sp_s;

    function automatic logic sel_is(input logic [SEL_W-1:0] sel, input int unsigned idx);
        return (32'(sel) == idx);
    endfunction

    function automatic logic sel_valid(input logic [SEL_W-1:0] sel);
        return (32'(sel) < SEL_END);
    endfunction

    function automatic logic [DATA_W-1:0] sp_zext(input logic [SP_W-1:0] v);
        return DATA_W'(v);
    endfunction

    assign rd_sel_s[0] = rd_sel0;
    assign rd_sel_s[1] = rd_sel1;
    assign rd_data0    = rd_data_s[0];
    assign rd_data1    = rd_data_s[1];

    // Read ports: stored value with write-through bypass; SP/ISR reads see only SP_W bits.
    always_comb begin
        rd_data_s = '0;
        for (int p = 0; p < 2; p++) begin
            if (sel_valid(rd_sel_s[p])) begin
                if (wr_en0 && (wr_sel0 == rd_sel_s[p])) begin
                    rd_data_s[p] = wr_data0;
                end else if (wr_en1 && (wr_sel1 == rd_sel_s[p])) begin
                    rd_data_s[p] = wr_data1;
                end else if (sel_is(rd_sel_s[p], SEL_SP)) begin
                    rd_data_s[p] = sp_zext(sp_q);
                end else if (sel_is(rd_sel_s[p], SEL_ISR)) begin
                    rd_data_s[p] = sp_zext(isr_q);
                end else begin
                    for (int k = 0; k < NUM_GPR; k++) begin
                        if (sel_is(rd_sel_s[p], k)) begin
                            rd_data_s[p] = gpr_q[k];
                        end else begin
                            rd_data_s[p] = rd_data_s[p];
                        end
                    end
                end
                // Truncate bypassed data for the narrow special registers.
                if (32'(rd_sel_s[p]) >= SEL_SP) begin
                    rd_data_s[p] = sp_zext(rd_data_s[p][SP_W-1:0]);
                end else begin
                    rd_data_s[p] = rd_data_s[p];
                end
            end else begin
                rd_data_s[p] = '0;
            end
        end
    end

    // GPR and ISR next state: port 0 has priority over port 1 on a shared target.
    always_comb begin
        gpr_d = gpr_q;
        for (int k = 0; k < NUM_GPR; k++) begin
            if (wr_en0 && sel_is(wr_sel0, k)) begin
                gpr_d[k] = wr_data0;
            end else if (wr_en1 && sel_is(wr_sel1, k)) begin
                gpr_d[k] = wr_data1;
            end else begin
                gpr_d[k] = gpr_q[k];
            end
        end
        if (wr_en0 && sel_is(wr_sel0, SEL_ISR)) begin
            isr_d = wr_data0[SP_W-1:0];
        end else if (wr_en1 && sel_is(wr_sel1, SEL_ISR)) begin
            isr_d = wr_data1[SP_W-1:0];
        end else begin
            isr_d = isr_q;
        end
    end

    assign wr0_sp_s = wr_en0 && sel_is(wr_sel0, SEL_SP);
    assign wr1_sp_s = wr_en1 && sel_is(wr_sel1, SEL_SP);

    // SP next state and sticky flags: an explicit write suppresses push/pop and flag events.
    always_comb begin
        sp_d  = sp_q;
        ovf_d = ovf_q & ~flag_clr;
        unf_d = unf_q & ~flag_clr;
        if (wr0_sp_s) begin
            sp_d = wr_data0[SP_W-1:0];
        end else if (wr1_sp_s) begin
            sp_d = wr_data1[SP_W-1:0];
        end else if (sp_push && sp_pop) begin
            sp_d = sp_q;
        end else if (sp_push) begin
            if (sp_q == '0) begin
                sp_d  = sp_q;
                ovf_d = 1'b1;
            end else begin
                sp_d = sp_q - SP_W'(1);
            end
        end else if (sp_pop) begin
            if (sp_q == SP_RESET) begin
                sp_d  = sp_q;
                unf_d = 1'b1;
            end else begin
                sp_d = sp_q + SP_W'(1);
            end
        end else begin
            sp_d = sp_q;
        end
    end

    // State registers with synchronous reset overriding all other activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            gpr_q <= '0;
            sp_q  <= SP_RESET;
            isr_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            gpr_q <= gpr_d;
            sp_q  <= sp_d;
            isr_q <= isr_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign regs_out_flat = gpr_q;
    assign sp_out        = sp_q;
    assign isr_out       = isr_q;
    assign stack_ovf     = ovf_q;
    assign stack_unf     = unf_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp with default parameters
// (8 GPRs, SP at select 8, ISR at select 9, SP reset value 12'hFFF).
module tb_regfile_mp;

    logic         clk;
    logic         rst;
    logic [3:0]   rd_sel0, rd_sel1;
    logic [15:0]  rd_data0, rd_data1;
    logic         wr_en0, wr_en1;
    logic [3:0]   wr_sel0, wr_sel1;
    logic [15:0]  wr_data0, wr_data1;
    logic         sp_push, sp_pop, flag_clr;
    logic         stack_ovf, stack_unf;
    logic [127:0] regs_out_flat;
    logic [11:0]  sp_out, isr_out;

    int n_checks;
    int n_fail;

    regfile_mp dut (
        .clk(clk), .rst(rst),
        .rd_sel0(rd_sel0), .rd_sel1(rd_sel1),
        .rd_data0(rd_data0), .rd_data1(rd_data1),
        .wr_en0(wr_en0), .wr_en1(wr_en1),
        .wr_sel0(wr_sel0), .wr_sel1(wr_sel1),
        .wr_data0(wr_data0), .wr_data1(wr_data1),
        .sp_push(sp_push), .sp_pop(sp_pop), .flag_clr(flag_clr),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf),
        .regs_out_flat(regs_out_flat),
        .sp_out(sp_out), .isr_out(isr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; wr_en0 = 1'b0; wr_en1 = 1'b0;
        wr_sel0 = 4'd0; wr_sel1 = 4'd0; wr_data0 = 16'h0; wr_data1 = 16'h0;
        sp_push = 1'b0; sp_pop = 1'b0; flag_clr = 1'b0;
    endtask

    // One rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle();
        rd_sel0 = 4'd0; rd_sel1 = 4'd0;

        // Reset state
        rst = 1'b1;
        tick();
        idle();
        #1;
        check_eq("rst_sp", sp_out, 12'hFFF);
        check_eq("rst_isr", isr_out, 12'h000);
        check_eq("rst_flat", regs_out_flat, 128'h0);
        check_eq("rst_ovf", stack_ovf, 1'b0);
        check_eq("rst_unf", stack_unf, 1'b0);
        rd_sel0 = 4'd8; #1;
        check_eq("rst_rd_sp", rd_data0, 16'h0FFF);

        // Dual write to different GPRs, same-cycle bypass, then stored readback
        wr_en0 = 1'b1; wr_sel0 = 4'd3; wr_data0 = 16'hA5A5;
        wr_en1 = 1'b1; wr_sel1 = 4'd5; wr_data1 = 16'h1234;
        rd_sel0 = 4'd3; rd_sel1 = 4'd5; #1;
        check_eq("byp_r3", rd_data0, 16'hA5A5);
        check_eq("byp_r5", rd_data1, 16'h1234);
        tick();
        idle(); #1;
        check_eq("st_r3", rd_data0, 16'hA5A5);
        check_eq("st_r5", rd_data1, 16'h1234);
        check_eq("flat_r3", regs_out_flat[63:48], 16'hA5A5);
        check_eq("flat_r5", regs_out_flat[95:80], 16'h1234);

        // Both ports hit R2: port 0 wins, in bypass and in storage
        wr_en0 = 1'b1; wr_sel0 = 4'd2; wr_data0 = 16'h1111;
        wr_en1 = 1'b1; wr_sel1 = 4'd2; wr_data1 = 16'h2222;
        rd_sel0 = 4'd2; rd_sel1 = 4'd2; #1;
        check_eq("conf_byp0", rd_data0, 16'h1111);
        check_eq("conf_byp1", rd_data1, 16'h1111);
        tick();
        idle(); #1;
        check_eq("conf_st", rd_data0, 16'h1111);
        check_eq("conf_flat", regs_out_flat[47:32], 16'h1111);

        // Port 1 bypass alone
        wr_en1 = 1'b1; wr_sel1 = 4'd4; wr_data1 = 16'hBEEF;
        rd_sel0 = 4'd4; rd_sel1 = 4'd3; #1;
        check_eq("byp1_r4", rd_data0, 16'hBEEF);
        check_eq("nobyp_r3", rd_data1, 16'hA5A5);
        tick();
        idle(); #1;

        // SP write (truncated), push down to zero, overflow, clear
        wr_en0 = 1'b1; wr_sel0 = 4'd8; wr_data0 = 16'hF002;
        rd_sel1 = 4'd8; #1;
        check_eq("sp_wr_byp", rd_data1, 16'h0002);
        tick();
        idle(); #1;
        check_eq("sp_wr", sp_out, 12'h002);
        sp_push = 1'b1;
        tick();
        check_eq("push1_sp", sp_out, 12'h001);
        check_eq("push1_rd_pre", rd_data1, 16'h0001);
        tick();
        check_eq("push2_sp", sp_out, 12'h000);
        check_eq("push2_ovf", stack_ovf, 1'b0);
        tick();
        check_eq("push3_sp", sp_out, 12'h000);
        check_eq("push3_ovf", stack_ovf, 1'b1);
        flag_clr = 1'b1;
        tick();
        check_eq("clr_vs_set", stack_ovf, 1'b1);
        sp_push = 1'b0;
        tick();
        check_eq("clr_ovf", stack_ovf, 1'b0);
        idle();

        // Underflow after reset, push+pop hold, then push
        rst = 1'b1; tick(); idle();
        sp_pop = 1'b1; tick();
        check_eq("pop_rst_sp", sp_out, 12'hFFF);
        check_eq("pop_unf", stack_unf, 1'b1);
        sp_push = 1'b1; tick();
        check_eq("pushpop_sp", sp_out, 12'hFFF);
        check_eq("pushpop_unf", stack_unf, 1'b1);
        sp_pop = 1'b0; tick();
        check_eq("push_fffe", sp_out, 12'hFFE);
        sp_push = 1'b0; sp_pop = 1'b1; tick();
        check_eq("pop_fff", sp_out, 12'hFFF);
        idle();
        flag_clr = 1'b1; tick(); idle();
        check_eq("unf_clr", stack_unf, 1'b0);

        // SP write beats push; ISR write via port 1
        wr_en1 = 1'b1; wr_sel1 = 4'd8; wr_data1 = 16'h0100; sp_push = 1'b1;
        wr_en0 = 1'b1; wr_sel0 = 4'd9; wr_data0 = 16'hABCD;
        tick(); idle();
        check_eq("wr_push_sp", sp_out, 12'h100);
        check_eq("wr_push_ovf", stack_ovf, 1'b0);
        check_eq("wr_push_unf", stack_unf, 1'b0);
        check_eq("isr_wr", isr_out, 12'hBCD);
        rd_sel0 = 4'd9; #1;
        check_eq("isr_rd", rd_data0, 16'h0BCD);

        // Invalid select 15: reads 0, write ignored, no bypass
        wr_en0 = 1'b1; wr_sel0 = 4'd7; wr_data0 = 16'h7777; tick(); idle();
        wr_en0 = 1'b1; wr_sel0 = 4'd15; wr_data0 = 16'hFFFF;
        rd_sel0 = 4'd15; #1;
        check_eq("inv_rd_byp", rd_data0, 16'h0000);
        tick(); idle(); #1;
        check_eq("inv_rd", rd_data0, 16'h0000);
        check_eq("inv_flat", regs_out_flat, {16'h7777, 112'h0});
        check_eq("inv_sp", sp_out, 12'h100);
        check_eq("inv_isr", isr_out, 12'hBCD);

        // Reset during a push at SP==0 with an active overflow
        wr_en0 = 1'b1; wr_sel0 = 4'd8; wr_data0 = 16'h0000; tick(); idle();
        sp_push = 1'b1; tick();
        check_eq("pre_rst_ovf", stack_ovf, 1'b1);
        wr_en1 = 1'b1; wr_sel1 = 4'd1; wr_data1 = 16'h5555;
        rst = 1'b1; tick(); idle(); #1;
        check_eq("rst2_sp", sp_out, 12'hFFF);
        check_eq("rst2_ovf", stack_ovf, 1'b0);
        check_eq("rst2_unf", stack_unf, 1'b0);
        check_eq("rst2_flat", regs_out_flat, 128'h0);
        check_eq("rst2_isr", isr_out, 12'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
